// File: rtl/simple_ram_arbiter.sv
// simple_ram_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between two
// native memory-port requesters. It issues at most one RAM access per cycle,
// uses round-robin fairness, and provides an optional lock. The lock lets one
// requester hold the RAM for read-modify-write sequences and is released by
// an idle timeout.
//
// Handshake: requester i presents req_valid[i] plus its request fields and
// holds them until the cycle in which req_ready[i] is also high; that cycle is
// the accept. req_ready[i] is never high without req_valid[i]. Read data
// returns on rsp_valid[i] for exactly one cycle, with no backpressure.
//
// Ports:
//   aclk, areset          clock (rising edge), synchronous active-high reset
//   req_valid/we/lock     per-requester request, write enable, lock-after-access
//   req_addr/req_wdata    requester i at slice i of the packed vectors
//   req_ready             per-requester grant
//   rsp_valid, rsp_rdata  per-requester read response valid, shared read data
//   mem_en/we/addr/wdata  RAM command, all zero when nothing is accepted
//   mem_rdata             RAM read data, valid the cycle after a read
//   lock_timeout_err      one-cycle pulse when a lock expires
//   dbg_state             current FSM state (0 = ARB, 1 = LOCKED)
module simple_ram_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]              req_lock,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    lock_timeout_err,
    output logic                    dbg_state
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic               owner;
    logic               rr_ptr;
    logic [CNT_W-1:0]   lock_cnt;

    logic [1:0]         eligible;
    logic               grant;
    logic               accept;

    // Requesters allowed to win this cycle: nobody in reset, only the owner
    // while locked, otherwise whoever is valid.
    always_comb begin
        eligible = 2'b00;
        if (!areset) begin
            if (state == LOCKED) begin
                eligible = owner ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
            end else begin
                eligible = req_valid;
            end
        end
    end

    // Contention goes to rr_ptr; a single eligible requester simply wins.
    assign grant     = (eligible == 2'b11) ? rr_ptr : eligible[1];
    assign accept    = |eligible;
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign mem_en    = accept;
    assign mem_we    = accept & req_we[grant];
    assign mem_addr  = !accept ? '0 :
                       grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign mem_wdata = !accept ? '0 :
                       grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

    // RAM read data is already aligned with rsp_valid, so pass it straight on.
    assign rsp_rdata = mem_rdata;
    assign dbg_state = (state == LOCKED);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= ARB;
            owner            <= 1'b0;
            rr_ptr           <= 1'b0;
            lock_cnt         <= '0;
            rsp_valid        <= 2'b00;
            lock_timeout_err <= 1'b0;
        end else begin
            rsp_valid        <= (accept && !req_we[grant]) ? (grant ? 2'b10 : 2'b01) : 2'b00;
            lock_timeout_err <= 1'b0;
            if (accept) begin
                if (req_lock[grant]) begin
                    // Enter or stay locked; the pointer is left alone so the
                    // other requester keeps its turn once the lock ends.
                    state    <= LOCKED;
                    owner    <= grant;
                    lock_cnt <= CNT_W'(LOCK_TIMEOUT);
                end else begin
                    state  <= ARB;
                    rr_ptr <= ~grant;
                end
            end else if (state == LOCKED) begin
                if (lock_cnt == CNT_W'(1)) begin
                    state            <= ARB;
                    rr_ptr           <= ~owner;
                    lock_timeout_err <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_simple_ram_arbiter.sv
// Testbench for simple_ram_arbiter (LOCK_TIMEOUT = 4). Directed vector table,
// one hand-written reset-during-lock sequence and randomized traffic, all
// checked against a behavioural reference model and a shadow RAM.
module tb_simple_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LT = 4;

    logic            clk;
    logic            areset;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_lock;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            lock_timeout_err;
    logic            dbg_state;

    simple_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_TIMEOUT(LT)) dut (
        .aclk(clk), .areset(areset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_lock(req_lock), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_timeout_err(lock_timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model: 1-cycle synchronous read ----------------
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_q;
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Model view: a lock is a claim by one requester that lapses after LT
    // consecutive cycles without an access by it. Fairness: under contention,
    // whoever was not served last (or not released last) wins.
    logic [DW-1:0] shadow [256];
    bit            m_locked;
    bit            m_owner;
    bit            m_last;
    int            m_idle;
    bit [1:0]      m_rsp;
    logic [DW-1:0] m_rdata;
    bit            m_err;
    bit            g_valid;
    bit            g;

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_last = 1; m_idle = 0;
        m_rsp = 0; m_err = 0;
    endtask

    // Called at the negedge: compare DUT against the model, then advance it.
    task automatic model_cycle();
        bit [1:0]      want;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        want = 2'b00;
        if (!areset) begin
            want = req_valid;
            if (m_locked) want = want & (m_owner ? 2'b10 : 2'b01);
        end
        g_valid = (want != 2'b00);
        if (want == 2'b11) g = ~m_last;
        else               g = want[1];
        w = g_valid && req_we[g];
        a = g ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
        d = g ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

        chk("req_ready", 64'(req_ready), g_valid ? (g ? 64'd2 : 64'd1) : 64'd0);
        chk("mem_en",    64'(mem_en),    64'(g_valid));
        chk("mem_we",    64'(mem_we),    64'(w));
        chk("mem_addr",  64'(mem_addr),  g_valid ? 64'(a) : 64'd0);
        chk("mem_wdata", 64'(mem_wdata), g_valid ? 64'(d) : 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        if (m_rsp != 2'b00) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        chk("timeout_err", 64'(lock_timeout_err), 64'(m_err));
        chk("state", 64'(dbg_state), 64'(m_locked));

        if (areset) begin
            model_reset();
        end else begin
            m_rsp = 0;
            m_err = 0;
            if (g_valid) begin
                if (w) shadow[a] = d;
                else begin
                    m_rsp   = g ? 2'b10 : 2'b01;
                    m_rdata = shadow[a];
                end
                if (req_lock[g]) begin
                    m_locked = 1; m_owner = g; m_idle = 0;
                end else begin
                    m_locked = 0; m_last = g;
                end
            end else if (m_locked) begin
                m_idle++;
                if (m_idle == LT) begin
                    m_locked = 0; m_last = m_owner; m_err = 1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] we,
                         input logic [1:0] lk, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        areset    = rst;
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic [1:0]    v, we, lk;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    e_ready, e_rsp;
        logic          e_err, e_lock, e_chk_rd;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] lk, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [1:0] e_ready,
                       input logic [1:0] e_rsp, input logic e_err, input logic e_lock,
                       input logic e_chk_rd, input logic [DW-1:0] e_rdata);
        vec_t r;
        r.rst = rst; r.v = v; r.we = we; r.lk = lk; r.a0 = a0; r.a1 = a1;
        r.d0 = d0; r.d1 = 32'h0;
        r.e_ready = e_ready; r.e_rsp = e_rsp; r.e_err = e_err; r.e_lock = e_lock;
        r.e_chk_rd = e_chk_rd; r.e_rdata = e_rdata;
        vecs.push_back(r);
    endtask

    // random-phase requester state (held until accepted)
    bit            p_v  [2];
    bit            p_we [2];
    bit            p_lk [2];
    logic [AW-1:0] p_a  [2];
    logic [DW-1:0] p_d  [2];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        ram_q = '0;
        areset = 1'b1; req_valid = 0; req_we = 0; req_lock = 0; req_addr = 0; req_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);

        //   rst v     we    lk    a0     a1     d0            ready rsp   err lk  rd  rdata
        add(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0);
        // requester 0: write then read back
        add(0, 2'b01, 2'b01, 2'b00, 8'h05, 8'h00, 32'hDEADBEEF, 2'b01, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 32'h0,        2'b01, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 2'b01, 0, 0, 1, 32'hDEADBEEF);
        // round-robin from reset
        add(1, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b01, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b10, 2'b01, 0, 0, 1, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b01, 2'b10, 0, 0, 1, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b10, 2'b01, 0, 0, 1, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b01, 2'b10, 0, 0, 1, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0,        2'b10, 2'b01, 0, 0, 1, 32'h0);
        add(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 2'b10, 0, 0, 1, 32'h0);
        // lock excludes requester 1 (t .. t+4)
        add(0, 2'b11, 2'b00, 2'b01, 8'h06, 8'h00, 32'h0,        2'b01, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h06, 8'h00, 32'h0,        2'b00, 2'b01, 0, 1, 1, 32'h0);
        add(0, 2'b11, 2'b01, 2'b01, 8'h06, 8'h00, 32'h77,       2'b01, 2'b00, 0, 1, 0, 32'h0);
        add(0, 2'b11, 2'b00, 2'b00, 8'h06, 8'h00, 32'h0,        2'b01, 2'b00, 0, 1, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h06, 8'h00, 32'h0,        2'b10, 2'b01, 0, 0, 1, 32'h77);
        // lock timeout (LT = 4)
        add(0, 2'b11, 2'b00, 2'b01, 8'h07, 8'h00, 32'h0,        2'b01, 2'b10, 0, 0, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h07, 8'h00, 32'h0,        2'b00, 2'b01, 0, 1, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h07, 8'h00, 32'h0,        2'b00, 2'b00, 0, 1, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h07, 8'h00, 32'h0,        2'b00, 2'b00, 0, 1, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h07, 8'h00, 32'h0,        2'b00, 2'b00, 0, 1, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h07, 8'h00, 32'h0,        2'b10, 2'b00, 1, 0, 0, 32'h0);
        add(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 2'b10, 0, 0, 0, 32'h0);
        // same-cycle write (req 0) / read (req 1) to address 3
        add(0, 2'b11, 2'b01, 2'b00, 8'h03, 8'h03, 32'h11,       2'b01, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b10, 2'b00, 2'b00, 8'h03, 8'h03, 32'h0,        2'b10, 2'b00, 0, 0, 0, 32'h0);
        add(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        2'b00, 2'b10, 0, 0, 1, 32'h11);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].we, vecs[i].lk,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            chk("vec_ready", 64'(req_ready), 64'(vecs[i].e_ready));
            chk("vec_rsp",   64'(rsp_valid), 64'(vecs[i].e_rsp));
            chk("vec_err",   64'(lock_timeout_err), 64'(vecs[i].e_err));
            chk("vec_state", 64'(dbg_state), 64'(vecs[i].e_lock));
            if (vecs[i].e_chk_rd) chk("vec_rdata", 64'(rsp_rdata), 64'(vecs[i].e_rdata));
            model_cycle();
        end

        // Reset while locked by requester 1 with a read response pending.
        drive(0, 2'b01, 2'b00, 2'b00, 8'h01, 8'h00, 32'h0, 32'h0);   // rr now favours 1
        @(negedge clk); model_cycle();
        drive(0, 2'b10, 2'b00, 2'b10, 8'h00, 8'h09, 32'h0, 32'h0);   // 1 reads and locks
        @(negedge clk); model_cycle();
        drive(1, 2'b11, 2'b00, 2'b00, 8'h00, 8'h09, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_pending_rsp", 64'(rsp_valid), 64'd2);
        chk("rst_locked", 64'(dbg_state), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd0);
        model_cycle();
        drive(0, 2'b11, 2'b00, 2'b00, 8'h00, 8'h09, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
        chk("post_rst_err", 64'(lock_timeout_err), 64'd0);
        chk("post_rst_state", 64'(dbg_state), 64'd0);
        chk("post_rst_grant", 64'(req_ready), 64'd1);
        model_cycle();

        // Randomized traffic, requests held until accepted.
        for (int i = 0; i < 2; i++) p_v[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            logic rst;
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && $urandom_range(0, 9) < 6) begin
                    p_v[i]  = 1;
                    p_we[i] = $urandom_range(0, 1);
                    p_lk[i] = ($urandom_range(0, 5) == 0);
                    p_a[i]  = AW'($urandom_range(0, 7));
                    p_d[i]  = $urandom;
                end
            end
            drive(rst, {p_v[1], p_v[0]}, {p_we[1], p_we[0]}, {p_lk[1], p_lk[0]},
                  p_a[0], p_a[1], p_d[0], p_d[1]);
            @(negedge clk);
            model_cycle();
            if (g_valid) p_v[g] = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
